mon_chain_sched: RTL

//  Sequencer for a daisy chain of 2-channel I/Q monitor slices (double integrator + serializer per channel).

---
 rtl/mon_chain_sched.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mon_chain_sched.sv
// Sequencer for a daisy chain of I/Q monitor slices: sample strobe generation,
// tail capture into a shadow bank, and banked frame handoff to the host.
module mon_chain_sched #(
  parameter int rwi   = 28,
  parameter int nchan = 8,
  parameter int aw    = 3,
  parameter int cw    = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic [cw-1:0]  cic_period,
  output logic           samp,
  output logic [rwi-1:0] s_head,
  output logic           g_head,
  input  logic [rwi-1:0] s_tail,
  input  logic           g_tail,
  output logic           frame_rdy,
  input  logic           frame_ack,
  input  logic [aw-1:0]  raddr,
  output logic [rwi-1:0] rdata,
  output logic [7:0]     overrun,
  output logic           err_short,
  input  logic           err_clr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  localparam int ww = $clog2(nchan + 1);
  localparam logic [ww-1:0] wfull = ww'(nchan);
  localparam logic [ww-1:0] wlast = ww'(nchan - 1);
  localparam logic [cw-1:0] pmin  = cw'(nchan + 3);

  logic [1:0]     state_reg;
  logic [cw-1:0]  pcnt_reg;
  logic [ww-1:0]  wcnt_reg;
  logic [rwi-1:0] shadow_reg [nchan];
  logic [rwi-1:0] bank_reg   [nchan];

  logic [cw-1:0] period_next;
  logic          capture;
  logic          frame_done;
  logic          commit;
  logic          drop;
  logic          short_frame;

  assign s_head = '0;
  assign g_head = 1'b0;

  // The period floor leaves room for a full frame of tail words between strobes.
  assign period_next = (cic_period < pmin) ? pmin : cic_period;
  assign samp        = (state_reg == RUN) && (pcnt_reg == '0);
  assign capture     = (state_reg == RUN) && enable && !samp && g_tail && (wcnt_reg < wfull);
  assign frame_done  = capture && (wcnt_reg == wlast);
  assign commit      = frame_done && (!frame_rdy || frame_ack);
  assign drop        = frame_done && frame_rdy && !frame_ack;
  assign short_frame = samp && (wcnt_reg != '0) && (wcnt_reg < wfull);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pcnt_reg  <= '0;
    end else if (!enable) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: state_reg <= LOAD;
        LOAD: begin
          pcnt_reg  <= period_next;
          state_reg <= RUN;
        end
        RUN:     pcnt_reg <= (pcnt_reg == '0) ? period_next : pcnt_reg - 1'b1;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_reg <= '0;
    end else if (!enable || (state_reg != RUN) || samp) begin
      wcnt_reg <= '0;
    end else if (capture) begin
      wcnt_reg <= wcnt_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < nchan; gi++) begin : g_word
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_reg[gi] <= '0;
        end else if (capture && (wcnt_reg == ww'(gi))) begin
          shadow_reg[gi] <= s_tail;
        end
      end

      // The last word bypasses the shadow so the whole frame lands in one cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bank_reg[gi] <= '0;
        end else if (commit) begin
          if (gi == nchan - 1) bank_reg[gi] <= s_tail;
          else                 bank_reg[gi] <= shadow_reg[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_rdy <= 1'b0;
    end else if (commit) begin
      frame_rdy <= 1'b1;
    end else if (frame_ack) begin
      frame_rdy <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= '0;
      err_short <= 1'b0;
    end else if (err_clr) begin
      overrun   <= '0;
      err_short <= 1'b0;
    end else begin
      if (drop && (overrun != 8'hFF)) overrun <= overrun + 8'd1;
      if (short_frame) err_short <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (32'(raddr) < nchan) begin
      rdata <= bank_reg[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule
